ps2_scan_rx: RTL and testbench

Parametrised PS/2 keyboard receiver for the parking-assigner front end. It samples the PS/2 clock and data lines at a divided rate and deframes 11-bit packets with start, parity and stop checks plus an inter-bit timeout. Make/break and extended prefixes (F0, E0) are folded into single key events, which are buffered in a FIFO with a valid/ready output handshake. Downstream control logic consumes one event per handshake instead of polling raw codewords.

---
 rtl/ps2_scan_rx.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit packets,
// folds E0/F0 prefixes into key events and queues them behind a valid/ready port.
module ps2_scan_rx #(
  parameter int unsigned CLK_DIV       = 250,
  parameter int unsigned TIMEOUT_TICKS = 4000,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PS2_CLK,
  input  logic             PS2_DATA,
  output logic             EVENT_VALID,
  input  logic             EVENT_READY,
  output logic [7:0]       EVENT_CODE,
  output logic             EVENT_EXT,
  output logic             EVENT_BREAK,
  output logic [CNT_W-1:0] FIFO_COUNT,
  output logic             ERR_PARITY,
  output logic             ERR_TIMEOUT,
  output logic             OVERFLOW
);

  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam int unsigned IW = $clog2(TIMEOUT_TICKS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 10;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          ps2_clk_s, ps2_dat_s;
  logic [TW-1:0] tick_cnt;
  logic          tick, prev_clk, fall;

  assign ps2_clk_s = clk_sync[1];
  assign ps2_dat_s = dat_sync[1];
  assign tick      = (tick_cnt == TW'(CLK_DIV - 1));
  assign fall      = tick & prev_clk & ~ps2_clk_s;

  // Input synchronisers, sample-tick divider and PS/2 clock edge detector
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      tick_cnt <= '0;
      prev_clk <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DATA};
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick) prev_clk <= ps2_clk_s;
    end
  end

  // Frame layout after 11 LSB-first shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop
  function automatic logic frame_ok(input logic [10:0] f);
    return !f[0] && f[10] && (^f[9:1]);
  endfunction

  state_t        state, state_d;
  logic [10:0]   shift_q, shift_d;
  logic [3:0]    bit_cnt, bit_cnt_d;
  logic [IW-1:0] idle_cnt, idle_cnt_d;
  logic          err_par_d, err_to_d;
  logic          byte_vld, byte_vld_d;
  logic [7:0]    byte_q, byte_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      shift_q     <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      ERR_PARITY  <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
      byte_vld    <= 1'b0;
      byte_q      <= '0;
    end else begin
      state       <= state_d;
      shift_q     <= shift_d;
      bit_cnt     <= bit_cnt_d;
      idle_cnt    <= idle_cnt_d;
      ERR_PARITY  <= err_par_d;
      ERR_TIMEOUT <= err_to_d;
      byte_vld    <= byte_vld_d;
      byte_q      <= byte_d;
    end
  end

  // Error strobes are evaluated one cycle early so they line up with CHECK / abort
  always_comb begin
    state_d    = state;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt;
    idle_cnt_d = idle_cnt;
    err_par_d  = 1'b0;
    err_to_d   = 1'b0;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    unique case (state)
      S_IDLE: begin
        if (fall) begin
          shift_d    = {ps2_dat_s, shift_q[10:1]};
          bit_cnt_d  = 4'd1;
          idle_cnt_d = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (fall) begin
          shift_d    = {ps2_dat_s, shift_q[10:1]};
          bit_cnt_d  = bit_cnt + 4'd1;
          idle_cnt_d = '0;
          if (bit_cnt == 4'd10) begin
            state_d   = S_CHECK;
            err_par_d = !frame_ok(shift_d);
          end
        end else if (tick) begin
          if (idle_cnt == IW'(TIMEOUT_TICKS - 1)) begin
            idle_cnt_d = '0;
            err_to_d   = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idle_cnt_d = idle_cnt + IW'(1);
          end
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (frame_ok(shift_q)) begin
          byte_vld_d = 1'b1;
          byte_d     = shift_q[8:1];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic          ext_f, brk_f, push;
  logic [EW-1:0] push_data;

  assign push      = byte_vld && (byte_q != 8'hE0) && (byte_q != 8'hF0);
  assign push_data = {ext_f, brk_f, byte_q};

  // Prefix flags; any framing error drops a half-received prefix sequence
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (ERR_PARITY || ERR_TIMEOUT) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (byte_vld) begin
      if (byte_q == 8'hE0) begin
        ext_f <= 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_f <= 1'b1;
      end else begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             pop, full, wr_en;

  assign pop   = EVENT_VALID && EVENT_READY;
  assign full  = (FIFO_COUNT == CNT_W'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);
  assign {EVENT_EXT, EVENT_BREAK, EVENT_CODE} = mem[rd_ptr];

  always_comb begin
    count_d = FIFO_COUNT;
    unique case ({wr_en, pop})
      2'b10:   count_d = FIFO_COUNT + CNT_W'(1);
      2'b01:   count_d = FIFO_COUNT - CNT_W'(1);
      default: count_d = FIFO_COUNT;
    endcase
  end

  // Event FIFO; entries reset so the head reads zero straight out of reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      FIFO_COUNT  <= '0;
      EVENT_VALID <= 1'b0;
      OVERFLOW    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      FIFO_COUNT  <= count_d;
      EVENT_VALID <= (count_d != '0);
      if (push && !wr_en) OVERFLOW <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: frames are bit-banged on the PS/2 lines, a
// byte-level reference model predicts events, and a monitor checks every handshake.
`timescale 1ns/1ps
module tb_ps2_scan_rx;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned TMO     = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CW      = 3;
  localparam int          H       = 32;  // PS/2 half period in CLK cycles (8 ticks)

  logic          CLK = 1'b0, RST_N = 1'b0, PS2_CLK = 1'b1, PS2_DATA = 1'b1, EVENT_READY = 1'b0;
  logic          EVENT_VALID, EVENT_EXT, EVENT_BREAK, ERR_PARITY, ERR_TIMEOUT, OVERFLOW;
  logic [7:0]    EVENT_CODE;
  logic [CW-1:0] FIFO_COUNT;

  int          vectors = 0, miscompares = 0, cyc = 0;
  int          exp_par = 0, exp_to = 0, seen_par = 0, seen_to = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  mon_ev;
  bit          m_ext = 0, m_brk = 0, exp_ovf = 0, rnd_ready = 0;

  ps2_scan_rx #(.CLK_DIV(CLK_DIV), .TIMEOUT_TICKS(TMO), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .EVENT_VALID(EVENT_VALID), .EVENT_READY(EVENT_READY), .EVENT_CODE(EVENT_CODE),
    .EVENT_EXT(EVENT_EXT), .EVENT_BREAK(EVENT_BREAK), .FIFO_COUNT(FIFO_COUNT),
    .ERR_PARITY(ERR_PARITY), .ERR_TIMEOUT(ERR_TIMEOUT), .OVERFLOW(OVERFLOW));

  always #5 CLK = ~CLK;

  // Cycles since reset release; sample ticks fall on multiples of CLK_DIV
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) cyc <= 0; else cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted head event must match the oldest predicted event
  always @(negedge CLK) begin
    if (RST_N) begin
      if (ERR_PARITY)  seen_par++;
      if (ERR_TIMEOUT) seen_to++;
      if (EVENT_VALID && EVENT_READY) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_event actual=%0h expected=none", {EVENT_EXT, EVENT_BREAK, EVENT_CODE});
        end else begin
          mon_ev = exp_q.pop_front();
          check("event", {EVENT_EXT, EVENT_BREAK, EVENT_CODE}, mon_ev);
        end
      end
    end
  end

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (exp_q.size() < int'(DEPTH)) exp_q.push_back({m_ext, m_brk, b});
      else exp_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic step();
    @(posedge CLK); #2;
    if (rnd_ready) EVENT_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_neg(input int target);
    int k = 0;
    do begin @(negedge CLK); k++; end while (cyc < target && k < 200);
    if (cyc != target) begin
      vectors++; miscompares++;
      $display("FAIL cycle_wait actual=%0d expected=%0d", cyc, target);
    end
  endtask

  function automatic int edge_cycle(input int n);
    int e = n + 3;
    while (e % int'(CLK_DIV) != 0) e++;
    return e;
  endfunction

  task automatic ps2_bit(input bit b, output int n);
    PS2_DATA = b;
    repeat (H / 2) step();
    PS2_CLK = 1'b0;
    n = cyc;
  endtask

  task automatic ps2_rise(input int n);
    while (cyc < n + H) step();
    PS2_CLK = 1'b1;
    repeat (H / 2) step();
  endtask

  // opts: 1 = check EVENT_VALID latency, 2 = one-cycle READY on the push cycle,
  //       4 = check FIFO_COUNT is 0 the cycle after the handshake
  task automatic send_frame(input logic [7:0] b, input int bad, input int opts);
    logic [10:0] f;
    int n, e, cnt;
    bit ok;
    f = {1'b1, ~^b, b, 1'b0};
    if (bad == 1) f[9] = ~f[9];
    if (bad == 2) f[10] = 1'b0;
    if (bad == 3) f[0] = 1'b1;
    ok = (bad == 0);
    if (!ok) exp_par++;
    for (int i = 0; i < 10; i++) begin
      ps2_bit(f[i], n);
      ps2_rise(n);
    end
    ps2_bit(f[10], n);
    e = edge_cycle(n);
    wait_neg(e);
    check("err_parity", ERR_PARITY, !ok);
    @(posedge CLK); #2;
    if (opts & 2) EVENT_READY = 1'b1;
    @(negedge CLK);
    if (opts & 1) check("valid_t2", EVENT_VALID, 0);
    @(posedge CLK); #1;
    if (opts & 2) EVENT_READY = 1'b0;
    model_byte(b, ok);
    cnt = exp_q.size();
    @(negedge CLK);
    check("fifo_count", FIFO_COUNT, cnt);
    if (opts & 1) check("valid_t3", EVENT_VALID, 1);
    if (opts & 4) begin
      @(negedge CLK);
      check("count_after_pop", FIFO_COUNT, 0);
    end
    ps2_rise(n);
  endtask

  task automatic send_partial(input int nbits, output int n);
    logic [10:0] f;
    f = {2'b11, 8'($urandom), 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_bit(f[i], n);
      ps2_rise(n);
    end
  endtask

  task automatic drain();
    EVENT_READY = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
    step(); step();
    @(negedge CLK);
    check("drain_queue", exp_q.size(), 0);
    check("drain_count", FIFO_COUNT, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e, bad, r;
    logic [7:0] b;
    #23;
    check("reset_outputs", {EVENT_VALID, EVENT_CODE, EVENT_EXT, EVENT_BREAK, FIFO_COUNT,
                            ERR_PARITY, ERR_TIMEOUT, OVERFLOW}, 0);
    @(posedge CLK); #2; RST_N = 1'b1;
    repeat (8) step();

    send_frame(8'h1C, 0, 1);
    drain();

    EVENT_READY = 1'b1;
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 4);
    drain();

    send_frame(8'h1C, 1, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 2, 0);
    send_frame(8'h1C, 0, 0);
    drain();

    send_frame(8'hF0, 0, 0);
    send_partial(5, n);
    e = edge_cycle(n);
    wait_neg(e + 60);
    check("timeout_early", ERR_TIMEOUT, 0);
    wait_neg(e + 64);
    check("timeout_pulse", ERR_TIMEOUT, 1);
    m_ext = 0; m_brk = 0; exp_to++;
    step();
    send_frame(8'h29, 0, 0);
    drain();

    EVENT_READY = 1'b0;
    send_frame(8'h16, 0, 0);
    send_frame(8'h1E, 0, 0);
    send_frame(8'h26, 0, 0);
    send_frame(8'h25, 0, 0);
    send_frame(8'h2E, 0, 0);
    check("overflow_set", OVERFLOW, exp_ovf);
    send_frame(8'h36, 0, 2);
    check("overflow_hold", OVERFLOW, 1);
    drain();
    check("overflow_sticky", OVERFLOW, exp_ovf);

    rnd_ready = 1;
    for (int i = 0; i < 24; i++) begin
      r   = $urandom_range(0, 9);
      b   = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      bad = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      send_frame(b, bad, 0);
    end
    rnd_ready = 0;
    drain();
    check("overflow_random", OVERFLOW, exp_ovf);

    EVENT_READY = 1'b0;
    send_frame(8'h11, 0, 0);
    send_frame(8'h12, 0, 0);
    send_partial(6, n);
    RST_N = 1'b0;
    #3;
    check("midframe_reset", {EVENT_VALID, EVENT_CODE, EVENT_EXT, EVENT_BREAK, FIFO_COUNT,
                             ERR_PARITY, ERR_TIMEOUT, OVERFLOW}, 0);
    exp_q.delete();
    m_ext = 0; m_brk = 0; exp_ovf = 0;
    repeat (3) @(posedge CLK);
    #2; RST_N = 1'b1;
    repeat (8) step();
    send_frame(8'h5A, 0, 1);
    drain();

    check("parity_pulses", seen_par, exp_par);
    check("timeout_pulses", seen_to, exp_to);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
